// File: rtl/adc_jesd204_pn_checker.sv
`default_nettype none
// ============================================================================
// Module   : adc_jesd204_pn_checker
// Brief    : Self-synchronising PN7/PN15 receive monitor for one ADC channel.
//            Sync status, sticky error flag, saturating error counter.
//            Optional macro ADC_PN_BIT_ERRCNT_EN: count mismatching bits
//            instead of mismatching beats.
// Revision : 1.0 - initial release
// ============================================================================
module adc_jesd204_pn_checker #(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int OOS_THRESHOLD   = 16,
    parameter int ERRCNT_WIDTH    = 32
) (
    input  logic                            adc_clk,
    input  logic                            adc_rst,
    input  logic                            adc_valid,
    input  logic [DATA_PATH_WIDTH*16-1:0]   adc_data,
    input  logic [3:0]                      adc_pn_sel,
    input  logic                            adc_pn_clr,
    output logic                            adc_pn_oos,
    output logic                            adc_pn_err,
    output logic [ERRCNT_WIDTH-1:0]         adc_pn_err_count
);

    localparam int         c_DW        = DATA_PATH_WIDTH * 16;
    localparam logic [7:0] c_THRESH_M1 = 8'(OOS_THRESHOLD - 1);

    typedef enum logic [0:0] {
        S_OOS     = 1'b0,
        S_IN_SYNC = 1'b1
    } state_t;

    // Expected beat from the 15 newest bits of the previous beat; each bit
    // depends only on higher-order bits, so resolve from the MSB down.
    function automatic logic [c_DW-1:0] pn_predict(input logic [14:0] prev,
                                                    input logic      pn7);
        logic [c_DW+14:0] f;
        f = '0;
        f[c_DW+14:c_DW] = prev;
        for (int i = c_DW - 1; i >= 0; i--) begin
            if (pn7)
                f[i] = f[i+7] ^ f[i+6];
            else
                f[i] = f[i+15] ^ f[i+14];
        end
        return f[c_DW-1:0];
    endfunction

    logic            w_enable, w_inv, w_pn7, w_sel_chg;
    logic [3:0]      r_sel;
    logic [c_DW-1:0] w_beat_in, r_beat, w_expect;
    logic            r_beat_vld;
    logic [14:0]     r_prev;
    logic            r_cmp_vld, r_match, w_match;
    state_t          r_state, w_state_nxt;
    logic [7:0]      r_match_cnt, w_match_cnt_nxt, r_miss_cnt, w_miss_cnt_nxt;
    logic            w_cmp_evt, w_err_evt;

    assign w_enable  = (adc_pn_sel[3:2] == 2'b01);
    assign w_inv     = w_enable && !adc_pn_sel[1];
    assign w_pn7     = !adc_pn_sel[0];
    assign w_sel_chg = (adc_pn_sel != r_sel);

    always_comb begin
        w_beat_in = '0;
        for (int l = 0; l < DATA_PATH_WIDTH; l++)
            w_beat_in[l*16 +: 16] = adc_data[(DATA_PATH_WIDTH-1-l)*16 +: 16];
        if (w_inv)
            w_beat_in = ~w_beat_in;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_sel      <= '0;
            r_beat_vld <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_sel      <= adc_pn_sel;
            r_beat_vld <= adc_valid;
            if (adc_valid)
                r_beat <= w_beat_in;
        end
    end

    assign w_expect = pn_predict(r_prev, w_pn7);
    assign w_match  = (r_beat == w_expect) && (r_beat != '0);

    // A select change drops whatever is already travelling down the pipe
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_prev    <= '0;
            r_cmp_vld <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_cmp_vld <= r_beat_vld && !w_sel_chg;
            if (r_beat_vld) begin
                r_prev  <= r_beat[14:0];
                r_match <= w_match;
            end
        end
    end

    assign w_cmp_evt = r_cmp_vld && !w_sel_chg && w_enable;
    assign w_err_evt = w_cmp_evt && (r_state == S_IN_SYNC) && !r_match;

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state     <= S_OOS;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        if (w_sel_chg || !w_enable) begin
            w_state_nxt     = S_OOS;
            w_match_cnt_nxt = '0;
            w_miss_cnt_nxt  = '0;
        end else if (r_cmp_vld) begin
            case (r_state)
                S_OOS: begin
                    if (!r_match)
                        w_match_cnt_nxt = '0;
                    else if (r_match_cnt == c_THRESH_M1) begin
                        w_state_nxt     = S_IN_SYNC;
                        w_match_cnt_nxt = '0;
                        w_miss_cnt_nxt  = '0;
                    end else
                        w_match_cnt_nxt = r_match_cnt + 8'd1;
                end
                S_IN_SYNC: begin
                    if (r_match)
                        w_miss_cnt_nxt = '0;
                    else if (r_miss_cnt == c_THRESH_M1) begin
                        w_state_nxt     = S_OOS;
                        w_miss_cnt_nxt  = '0;
                        w_match_cnt_nxt = '0;
                    end else
                        w_miss_cnt_nxt = r_miss_cnt + 8'd1;
                end
                default: w_state_nxt = S_OOS;
            endcase
        end
    end

    assign adc_pn_oos = (r_state == S_OOS);

    always_ff @(posedge adc_clk) begin
        if (adc_rst || adc_pn_clr)
            adc_pn_err <= 1'b0;
        else if (w_err_evt)
            adc_pn_err <= 1'b1;
    end

`ifdef ADC_PN_BIT_ERRCNT_EN
    localparam int c_POP_W = $clog2(c_DW + 1);
    localparam int c_SUM_W = ERRCNT_WIDTH + c_POP_W;

    function automatic logic [c_POP_W-1:0] popcount(input logic [c_DW-1:0] v);
        logic [c_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_DW; i++)
            n = n + c_POP_W'(v[i]);
        return n;
    endfunction

    logic [c_DW-1:0]    r_diff;
    logic [c_POP_W-1:0] r_pop;
    logic               r_pop_add;
    logic [c_SUM_W-1:0] w_sum;

    // An all-zero beat is charged as every bit wrong
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_diff    <= '0;
            r_pop     <= '0;
            r_pop_add <= 1'b0;
        end else begin
            if (r_beat_vld)
                r_diff <= (r_beat == '0) ? '1 : (r_beat ^ w_expect);
            r_pop     <= popcount(r_diff);
            r_pop_add <= w_err_evt && !adc_pn_clr;
        end
    end

    assign w_sum = {{c_POP_W{1'b0}}, adc_pn_err_count} + {{ERRCNT_WIDTH{1'b0}}, r_pop};

    always_ff @(posedge adc_clk) begin
        if (adc_rst || adc_pn_clr)
            adc_pn_err_count <= '0;
        else if (r_pop_add)
            adc_pn_err_count <= (|w_sum[c_SUM_W-1:ERRCNT_WIDTH]) ? '1
                                                                 : w_sum[ERRCNT_WIDTH-1:0];
    end
`else
    always_ff @(posedge adc_clk) begin
        if (adc_rst || adc_pn_clr)
            adc_pn_err_count <= '0;
        else if (w_err_evt && (adc_pn_err_count != '1))
            adc_pn_err_count <= adc_pn_err_count + 1'b1;
    end
`endif

endmodule
`default_nettype wire
